ncl_mult3_host: RTL and testbench
=================================

NCL_MULT3_HOST -- requirements
Module: ncl_mult3_host

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop depth of every asynchronous-input synchronizer, legal range 2..3.
REQ-002 Parameter TIMEOUT, default 255: max clk cycles allowed per NCL phase before abort, legal range 15..65535.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 in_a, in_b  input  3 each  unsigned binary operands.
REQ-008 a_rail1, a_rail0, b_rail1, b_rail0  output  3 each  dual-rail operands to the NCL multiplier; bit i of each pair forms one dual-rail signal.
REQ-009 ko_in  input  1  multiplier Ko, asynchronous; 1 = request-for-DATA, 0 = request-for-NULL.
REQ-010 p_rail1, p_rail0  input  6 each  dual-rail product from the multiplier, asynchronous.
REQ-011 ki_out  output  1  Ki to the multiplier output registers; 1 = accept DATA, 0 = accept NULL.
REQ-012 out_valid  output  1  decoded product available.
REQ-013 out_ready  input  1  consumer accepts the product.
REQ-014 out_p  output  6  binary product.
REQ-015 out_err  output  1  one-cycle pulse on timeout or illegal rail code.

Function
REQ-016 ko_in, p_rail1 and p_rail0 SHALL pass through SYNC_STAGES-deep synchronizers before any use.
REQ-017 Each bit SHALL be classified as NULL (00), DATA0 (01 = rail0 high), DATA1 (10 = rail1 high) or ILLEGAL (11); the product is complete when all 6 bits are DATA on two consecutive synchronized samples; the product is empty when all 12 rails are 0 on two consecutive synchronized samples.
REQ-018 The FSM SHALL have the states IDLE, DATA, HOLD, NULL and RECOVER.
REQ-019 IDLE: in_ready=1 and all rails 0; on in_valid the block latches in_a and in_b and moves to DATA.
REQ-020 DATA: the block drives rail1=operand bit and rail0=~operand bit, starting the cycle after acceptance; when ko_in is synchronized-low and the product is complete, it latches out_p=p_rail1 and moves to HOLD.
REQ-021 HOLD: out_valid=1 with out_p stable and rails still at DATA; on out_ready the block moves to NULL in the next cycle.
REQ-022 NULL: all operand rails SHALL be 0 and ki_out=0; when ko_in is synchronized-high and the product is empty, the block sets ki_out=1 and returns to IDLE.
REQ-023 ki_out SHALL be 1 in every state except NULL and RECOVER.
REQ-024 An ILLEGAL bit on any synchronized sample in DATA or HOLD SHALL pulse out_err and move the FSM to RECOVER, with no out_valid.
REQ-025 Per-phase counter: it clears on each state entry and increments in DATA and NULL; reaching TIMEOUT SHALL pulse out_err, with DATA moving to RECOVER and NULL staying in NULL with the counter reset.
REQ-026 RECOVER behaves as NULL but never asserts out_valid; when the product is empty and ko_in is high, it returns to IDLE.
REQ-027 A new in_valid SHALL NOT be accepted before the NULL wavefront completes (no DATA-to-DATA transition).
REQ-028 out_valid SHALL be held while out_ready=0 for an unbounded time, with no timeout counted in HOLD.
REQ-029 Minimum transaction length is 1 accept cycle + 2×(SYNC_STAGES+2) + 1 cycles.

Reset
REQ-030 rst=1 SHALL immediately set: state=IDLE, all operand rails 0, ki_out=1, in_ready=0, out_valid=0, out_p=0, out_err=0, counter 0, and all synchronizers 0.
REQ-031 in_ready SHALL rise only on the first clk edge after rst deasserts; reset mid-transaction SHALL abandon it with no out_valid and no out_err.

Structure
REQ-032 Package ncl_pkg SHALL hold the dual_rail_logic typedef, the rail-code constants (NULL/DATA0/DATA1/ILLEGAL) and the FSM state enum.
REQ-033 One sub-module SHALL be used: ncl_sync, a parameterized N-bit, SYNC_STAGES-deep synchronizer with asynchronous reset, instantiated for ko_in and the 12 product rails.

Verification
REQ-034 Operands 7×7 with a behavioural NCL multiplier model -> out_p=6'b110001 (49), rails return to 0, ki_out sequence 1→0→1.
REQ-035 5×3 then 0×0 back-to-back -> out_p=15 then 0; no second acceptance before the product is empty.
REQ-036 out_ready held 0 for 1000 cycles after a 6×2 product -> out_valid and out_p=12 stable throughout; no out_err.
REQ-037 Model never lowers Ko -> out_err pulse at TIMEOUT cycles after DATA entry, then RECOVER, then IDLE once the model returns NULL.
REQ-038 Product bit 3 forced to 11 -> out_err pulse, no out_valid, recovery to IDLE.
REQ-039 rst asserted during HOLD -> all outputs at reset values in the same cycle; a following 4×4 transaction yields 16.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared types for the NCL multiplier host: dual-rail encoding, rail codes and FSM states.
package ncl_pkg;

    // {rail1, rail0}
    typedef logic [1:0] dual_rail_logic;

    localparam dual_rail_logic DrNull    = 2'b00;
    localparam dual_rail_logic DrData0   = 2'b01;
    localparam dual_rail_logic DrData1   = 2'b10;
    localparam dual_rail_logic DrIllegal = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StHold,
        StNull,
        StRecover
    } state_e;

    function automatic dual_rail_logic dr_pack(input logic rail1, input logic rail0);
        return {rail1, rail0};
    endfunction

endpackage

// File: rtl/ncl_mult3_host_if.sv
// Bundles the binary handshake and the dual-rail NCL multiplier signals of ncl_mult3_host.
interface ncl_mult3_host_if;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic [2:0] a_rail1;
    logic [2:0] a_rail0;
    logic [2:0] b_rail1;
    logic [2:0] b_rail0;
    logic       ko_in;
    logic [5:0] p_rail1;
    logic [5:0] p_rail0;
    logic       ki_out;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_p;
    logic       out_err;

    // master: the host block; slave: producer/consumer and the NCL multiplier around it
    modport master (
        input  in_valid, in_a, in_b, ko_in, p_rail1, p_rail0, out_ready,
        output in_ready, a_rail1, a_rail0, b_rail1, b_rail0, ki_out, out_valid, out_p, out_err
    );

    modport slave (
        output in_valid, in_a, in_b, ko_in, p_rail1, p_rail0, out_ready,
        input  in_ready, a_rail1, a_rail0, b_rail1, b_rail0, ki_out, out_valid, out_p, out_err
    );

endinterface

// File: rtl/ncl_sync.sv
// N-bit multi-flop synchronizer with asynchronous reset for signals from the NCL domain.
module ncl_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_mult3_host.sv
// Host for a 3x3 NCL multiplier: turns a binary valid/ready pair into the four-phase
// DATA/NULL dual-rail protocol and decodes the dual-rail product back to binary.
module ncl_mult3_host
    import ncl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic              clk,
    input logic              rst,
    ncl_mult3_host_if.master bus
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  a_q, a_d, b_q, b_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  out_p_q, out_p_d;
    logic        out_err_q, out_err_d;
    logic        out_valid_q, in_ready_q, ki_q;
    logic [2:0]  a1_q, a0_q, b1_q, b0_q;
    logic        complete_q, empty_q;

    logic        ko_s;
    logic [11:0] p_s;
    logic [5:0]  p1_s, p0_s;
    logic [5:0]  bit_data, bit_ill;
    logic        complete_now, empty_now, illegal;
    logic        complete, empty, in_data;

    ncl_sync #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ko (
        .clk (clk),
        .rst (rst),
        .d   (bus.ko_in),
        .q   (ko_s)
    );

    ncl_sync #(
        .WIDTH       (12),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_p (
        .clk (clk),
        .rst (rst),
        .d   ({bus.p_rail1, bus.p_rail0}),
        .q   (p_s)
    );

    assign p1_s = p_s[11:6];
    assign p0_s = p_s[5:0];

    always_comb begin
        bit_data = '0;
        bit_ill  = '0;
        for (int i = 0; i < 6; i++) begin
            case (dr_pack(p1_s[i], p0_s[i]))
                DrData0, DrData1: bit_data[i] = 1'b1;
                DrIllegal:        bit_ill[i]  = 1'b1;
                default:          ;
            endcase
        end
    end

    assign complete_now = &bit_data;
    assign empty_now    = (p_s == 12'd0);
    assign illegal      = |bit_ill;
    // Wavefronts are only trusted once seen on two consecutive synchronized samples.
    assign complete     = complete_now & complete_q;
    assign empty        = empty_now & empty_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        out_p_d   = out_p_q;
        out_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    state_d = StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 16'd1;
                if (illegal) begin
                    out_err_d = 1'b1;
                    state_d   = StRecover;
                end else if (!ko_s && complete) begin
                    out_p_d = p1_s;
                    state_d = StHold;
                end else if (cnt_q == TimeoutLast) begin
                    out_err_d = 1'b1;
                    state_d   = StRecover;
                end
            end
            StHold: begin
                if (illegal) begin
                    out_err_d = 1'b1;
                    state_d   = StRecover;
                end else if (bus.out_ready) begin
                    state_d = StNull;
                end
            end
            StNull: begin
                cnt_d = cnt_q + 16'd1;
                if (ko_s && empty) begin
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    out_err_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            StRecover: begin
                if (ko_s && empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign in_data = (state_d == StData) || (state_d == StHold);

    // Outputs toward the asynchronous core are registered so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            ki_q        <= 1'b1;
            a1_q        <= '0;
            a0_q        <= '0;
            b1_q        <= '0;
            b0_q        <= '0;
            complete_q  <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            out_p_q     <= out_p_d;
            out_err_q   <= out_err_d;
            out_valid_q <= (state_d == StHold);
            in_ready_q  <= (state_d == StIdle);
            ki_q        <= !((state_d == StNull) || (state_d == StRecover));
            a1_q        <= in_data ? a_d : 3'd0;
            a0_q        <= in_data ? ~a_d : 3'd0;
            b1_q        <= in_data ? b_d : 3'd0;
            b0_q        <= in_data ? ~b_d : 3'd0;
            complete_q  <= complete_now;
            empty_q     <= empty_now;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.a_rail1   = a1_q;
    assign bus.a_rail0   = a0_q;
    assign bus.b_rail1   = b1_q;
    assign bus.b_rail0   = b0_q;
    assign bus.ki_out    = ki_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ncl_mult3_host.sv
// Self-checking bench for ncl_mult3_host with a behavioural NCL multiplier model.
module tb_ncl_mult3_host;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TMO  = 60;

    typedef enum int {MdNormal, MdStuck, MdIllegal} mode_e;

    logic  clk       = 1'b0;
    logic  rst       = 1'b0;
    int    n_cmp     = 0;
    int    n_bad     = 0;
    int    early_cnt = 0;
    mode_e mode      = MdNormal;

    ncl_mult3_host_if bus ();

    ncl_mult3_host #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit ops_data();
        return (&(bus.a_rail1 ^ bus.a_rail0)) && (&(bus.b_rail1 ^ bus.b_rail0));
    endfunction

    function automatic bit ops_null();
        return {bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0} == 12'd0;
    endfunction

    function automatic bit prod_empty();
        return {bus.p_rail1, bus.p_rail0} == 12'd0;
    endfunction

    // Multiplier core plus output register: latches DATA when Ki=1, NULL when Ki=0.
    initial begin : model
        int         dly;
        logic [5:0] pv;
        dly         = 0;
        bus.ko_in   = 1'b1;
        bus.p_rail1 = '0;
        bus.p_rail0 = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.ko_in   = 1'b1;
                bus.p_rail1 = '0;
                bus.p_rail0 = '0;
                dly         = 0;
            end else if (mode != MdStuck && bus.ko_in && prod_empty() && ops_data()
                         && bus.ki_out) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    pv          = {3'b0, bus.a_rail1} * {3'b0, bus.b_rail1};
                    bus.p_rail1 = pv;
                    bus.p_rail0 = ~pv;
                    if (mode == MdIllegal) begin
                        bus.p_rail1[3] = 1'b1;
                        bus.p_rail0[3] = 1'b1;
                    end
                    bus.ko_in = 1'b0;
                    dly       = $urandom_range(0, 3);
                end
            end else if (!bus.ko_in && ops_null() && !bus.ki_out) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    bus.p_rail1 = '0;
                    bus.p_rail0 = '0;
                    bus.ko_in   = 1'b1;
                    dly         = $urandom_range(0, 3);
                end
            end
        end
    end

    // Counts cycles where a new operand pair could be taken before the NULL wavefront is done.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.in_ready === 1'b1 && (!prod_empty() || !ops_null())) early_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic offer(input logic [2:0] a, input logic [2:0] b, output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok           = (bus.in_ready === 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit idle_ok, inout bit ki_low, inout bit err_seen);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            if (bus.ki_out === 1'b0) ki_low = 1'b1;
            if (bus.out_err === 1'b1) err_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        idle_ok = (bus.in_ready === 1'b1);
    endtask

    // Full transaction with the consumer stalling for 'hold' cycles; results only, no checks.
    task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input int hold,
                           output bit ok_valid, output logic [5:0] p, output bit stable,
                           output bit err_seen, output bit ki_low, output bit idle_ok);
        bit ok;
        int n = 0;
        err_seen = 1'b0;
        ki_low   = 1'b0;
        stable   = 1'b1;
        offer(a, b, ok);
        while (bus.out_valid !== 1'b1 && n < 400) begin
            if (bus.out_err === 1'b1) err_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        ok_valid = ok && (bus.out_valid === 1'b1);
        p        = bus.out_p;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_p !== p) stable = 1'b0;
            if (bus.out_err === 1'b1) err_seen = 1'b1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        wait_idle(idle_ok, ki_low, err_seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: rdy=%b vld=%b err=%b want 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_err);
        end
        n_cmp++;
        if (bus.ki_out !== 1'b1 || bus.out_p !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_ki_p: ki=%b p=%0d want 1 0", bus.ki_out, bus.out_p);
        end
        n_cmp++;
        if ({bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_rails: got %h want 000",
                     {bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: got %b want 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_first_edge: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_7x7();
        bit ok_valid, stable, err_seen, ki_low, idle_ok;
        logic [5:0] p;
        logic       ki_start;
        ki_start = bus.ki_out;
        run_txn(3'd7, 3'd7, 2, ok_valid, p, stable, err_seen, ki_low, idle_ok);
        n_cmp++;
        if (!ok_valid || p !== 6'b110001) begin
            n_bad++;
            $display("FAIL mult_7x7: valid=%b p=%0d want 1 49", ok_valid, p);
        end
        n_cmp++;
        if (ki_start !== 1'b1 || !ki_low || bus.ki_out !== 1'b1) begin
            n_bad++;
            $display("FAIL ki_seq: start=%b low=%b end=%b want 1 1 1",
                     ki_start, ki_low, bus.ki_out);
        end
        n_cmp++;
        if (!idle_ok || err_seen || !ops_null()) begin
            n_bad++;
            $display("FAIL 7x7_return: idle=%b err=%b rails_null=%b want 1 0 1",
                     idle_ok, err_seen, ops_null());
        end
    endtask

    task automatic test_back_to_back();
        bit ok_valid, stable, err_seen, ki_low, idle_ok;
        logic [5:0] p;
        early_cnt = 0;
        run_txn(3'd5, 3'd3, 0, ok_valid, p, stable, err_seen, ki_low, idle_ok);
        n_cmp++;
        if (!ok_valid || p !== 6'd15 || err_seen) begin
            n_bad++;
            $display("FAIL b2b_5x3: valid=%b p=%0d err=%b want 1 15 0", ok_valid, p, err_seen);
        end
        run_txn(3'd0, 3'd0, 0, ok_valid, p, stable, err_seen, ki_low, idle_ok);
        n_cmp++;
        if (!ok_valid || p !== 6'd0 || err_seen) begin
            n_bad++;
            $display("FAIL b2b_0x0: valid=%b p=%0d err=%b want 1 0 0", ok_valid, p, err_seen);
        end
        n_cmp++;
        if (early_cnt != 0) begin
            n_bad++;
            $display("FAIL early_accept: got %0d cycles want 0", early_cnt);
        end
    endtask

    task automatic test_hold_stall();
        bit ok_valid, stable, err_seen, ki_low, idle_ok;
        logic [5:0] p;
        run_txn(3'd6, 3'd2, 1000, ok_valid, p, stable, err_seen, ki_low, idle_ok);
        n_cmp++;
        if (!ok_valid || p !== 6'd12 || !stable) begin
            n_bad++;
            $display("FAIL hold_stall: valid=%b p=%0d stable=%b want 1 12 1", ok_valid, p, stable);
        end
        n_cmp++;
        if (err_seen || !idle_ok) begin
            n_bad++;
            $display("FAIL hold_err: err=%b idle=%b want 0 1", err_seen, idle_ok);
        end
    endtask

    task automatic test_random();
        bit ok_valid, stable, err_seen, ki_low, idle_ok;
        logic [5:0] p, exp;
        logic [2:0] a, b;
        for (int k = 0; k < 8; k++) begin
            a   = 3'($urandom_range(0, 7));
            b   = 3'($urandom_range(0, 7));
            exp = {3'b0, a} * {3'b0, b};
            run_txn(a, b, int'($urandom_range(0, 5)), ok_valid, p, stable, err_seen, ki_low,
                    idle_ok);
            n_cmp++;
            if (!ok_valid || p !== exp || err_seen || !stable) begin
                n_bad++;
                $display("FAIL random_%0dx%0d: valid=%b p=%0d err=%b want 1 %0d 0",
                         a, b, ok_valid, p, err_seen, exp);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok, idle_ok, ki_low, err_dummy;
        bit valid_seen = 1'b0;
        int n = 0;
        mode = MdStuck;
        offer(3'd3, 3'd5, ok);
        n_cmp++;
        if (!ok || bus.a_rail1 !== 3'd3 || bus.a_rail0 !== 3'd4) begin
            n_bad++;
            $display("FAIL tmo_data_entry: a1=%0d a0=%0d want 3 4", bus.a_rail1, bus.a_rail0);
        end
        while (bus.out_err !== 1'b1 && n < int'(4 * TMO)) begin
            if (bus.out_valid === 1'b1) valid_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != int'(TMO)) begin
            n_bad++;
            $display("FAIL tmo_cycles: got %0d want %0d", n, TMO);
        end
        n_cmp++;
        if (bus.ki_out !== 1'b0 || !ops_null()) begin
            n_bad++;
            $display("FAIL tmo_recover: ki=%b rails_null=%b want 0 1", bus.ki_out, ops_null());
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_pulse: got %b want 0", bus.out_err);
        end
        ki_low    = 1'b0;
        err_dummy = 1'b0;
        wait_idle(idle_ok, ki_low, err_dummy);
        n_cmp++;
        if (!idle_ok || valid_seen) begin
            n_bad++;
            $display("FAIL tmo_idle: idle=%b valid_seen=%b want 1 0", idle_ok, valid_seen);
        end
        mode = MdNormal;
    endtask

    task automatic test_illegal();
        bit ok, idle_ok, ki_low, err_dummy;
        bit valid_seen = 1'b0;
        int n = 0;
        mode = MdIllegal;
        offer(3'd2, 3'd5, ok);
        while (bus.out_err !== 1'b1 && n < 200) begin
            if (bus.out_valid === 1'b1) valid_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.out_err !== 1'b1 || valid_seen) begin
            n_bad++;
            $display("FAIL illegal_err: err=%b valid_seen=%b want 1 0", bus.out_err, valid_seen);
        end
        mode      = MdNormal;
        ki_low    = 1'b0;
        err_dummy = 1'b0;
        @(negedge clk);
        wait_idle(idle_ok, ki_low, err_dummy);
        n_cmp++;
        if (!idle_ok || bus.out_valid !== 1'b0 || !ki_low) begin
            n_bad++;
            $display("FAIL illegal_recover: idle=%b vld=%b ki_low=%b want 1 0 1",
                     idle_ok, bus.out_valid, ki_low);
        end
    endtask

    task automatic test_reset_in_hold();
        bit ok, ok_valid, stable, err_seen, ki_low, idle_ok;
        logic [5:0] p;
        int n = 0;
        offer(3'd6, 3'd7, ok);
        while (bus.out_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_p !== 6'd42) begin
            n_bad++;
            $display("FAIL pre_reset_hold: vld=%b p=%0d want 1 42", bus.out_valid, bus.out_p);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_p !== 6'd0 || bus.out_err !== 1'b0
            || bus.in_ready !== 1'b0 || bus.ki_out !== 1'b1 || !ops_null()) begin
            n_bad++;
            $display("FAIL rst_in_hold: vld=%b p=%0d err=%b rdy=%b ki=%b want 0 0 0 0 1",
                     bus.out_valid, bus.out_p, bus.out_err, bus.in_ready, bus.ki_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_txn(3'd4, 3'd4, 1, ok_valid, p, stable, err_seen, ki_low, idle_ok);
        n_cmp++;
        if (!ok_valid || p !== 6'd16 || err_seen) begin
            n_bad++;
            $display("FAIL post_rst_4x4: valid=%b p=%0d err=%b want 1 16 0", ok_valid, p, err_seen);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_7x7();
        test_back_to_back();
        test_hold_stall();
        test_random();
        test_timeout();
        test_illegal();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
